// File: rtl/uart_rx_param_if.sv
// Receiver-to-consumer bundle: received word, error flags, valid/ready handshake and status.
// The receiver drives through master; the consumer side (FIFO, CPU register) uses slave.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output rx_data, rx_valid, parity_err, frame_err, overrun, busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err, overrun, busy,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop input synchroniser, mid-bit sampling, glitch rejection,
// parity/framing flags and a valid/ready output with overrun detection.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    uart_rx_param_if.master   bus
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_DONE} state_t;

    state_t                r_state;
    logic                  r_sync1, r_sync2;
    logic [CW-1:0]         r_cnt;
    logic [BW-1:0]         r_bit_cnt;
    logic                  r_stop_cnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_par_bad, r_frm_bad;
    logic                  r_armed;
    logic [DATA_BITS-1:0]  r_data;
    logic                  r_valid, r_perr, r_ferr, r_overrun;

    logic w_rx_s, w_sample, w_accept;
    assign w_rx_s   = r_sync2;
    assign w_sample = (r_cnt == FULL_M1);
    assign w_accept = r_valid & bus.rx_ready;

    assign bus.rx_data    = r_data;
    assign bus.rx_valid   = r_valid;
    assign bus.parity_err = r_perr;
    assign bus.frame_err  = r_ferr;
    assign bus.overrun    = r_overrun;
    assign bus.busy       = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_cnt      <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_par_bad  <= 1'b0;
            r_frm_bad  <= 1'b0;
            r_armed    <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_sync1   <= rx;
            r_sync2   <= r_sync1;
            r_overrun <= 1'b0;
            if (w_accept)
                r_valid <= 1'b0;

            case (r_state)
                // Arming requires a high line after each frame, so a held break never retriggers.
                S_IDLE: begin
                    if (w_rx_s) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_cnt   <= '0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt == HALF_M1) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state    <= S_DATA;
                            r_bit_cnt  <= '0;
                            r_stop_cnt <= 1'b0;
                            r_par_bad  <= 1'b0;
                            r_frm_bad  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_sample) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == LAST_BIT)
                            r_state <= (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_PAR: begin
                    if (w_sample) begin
                        r_cnt     <= '0;
                        r_par_bad <= (PARITY == 1) ? ~(^r_shift ^ w_rx_s) : (^r_shift ^ w_rx_s);
                        r_state   <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_sample) begin
                        r_cnt <= '0;
                        if (!w_rx_s)
                            r_frm_bad <= 1'b1;
                        if (r_stop_cnt == STOP_LAST)
                            r_state <= S_DONE;
                        else
                            r_stop_cnt <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                // A word accepted in this same cycle frees the slot, so the new word still loads.
                S_DONE: begin
                    if (!r_valid || w_accept) begin
                        r_data  <= r_shift;
                        r_perr  <= r_par_bad;
                        r_ferr  <= r_frm_bad;
                        r_valid <= 1'b1;
                    end else begin
                        r_overrun <= 1'b1;
                    end
                    r_armed <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: two instances (8E1 and 7N2) fed by a line-level UART transmitter
// model; expected words go into per-instance queues, monitors pop them on each handshake.
module tb_uart_rx_param;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_a = 1'b1;
    logic rx_b = 1'b1;

    uart_rx_param_if #(.DATA_BITS(8)) bus_a ();
    uart_rx_param_if #(.DATA_BITS(7)) bus_b ();

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .rx(rx_a), .bus(bus_a)
    );
    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rx(rx_b), .bus(bus_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] data;
        bit         perr;
        bit         ferr;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   errors = 0;
    int   ovr_a  = 0;
    int   ovr_b  = 0;
    bit   hold_a = 1'b0;
    bit   hold_b = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_line(input int which, input bit v);
        if (which == 0) rx_a = v;
        else            rx_b = v;
    endtask

    // Line-level transmitter: start, LSB-first data, optional even parity, stop bits, idle gap.
    task automatic send(input int which, input logic [8:0] d, input bit bad_par,
                        input bit bad_stop, input int gap_bits, input bit push);
        int   nb;
        int   stops;
        bit   par_en;
        bit   bits[$];
        exp_t e;
        nb     = (which == 0) ? 8 : 7;
        stops  = (which == 0) ? 1 : 2;
        par_en = (which == 0);
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) bits.push_back(d[i]);
        if (par_en) bits.push_back((^d[7:0]) ^ bad_par);
        for (int i = 0; i < stops; i++) bits.push_back(!bad_stop);
        for (int i = 0; i < gap_bits; i++) bits.push_back(1'b1);
        if (push) begin
            e.data = (which == 0) ? (d & 9'h0FF) : (d & 9'h07F);
            e.perr = par_en && bad_par;
            e.ferr = bad_stop;
            if (which == 0) q_a.push_back(e);
            else            q_b.push_back(e);
        end
        @(negedge clk);
        foreach (bits[i]) begin
            drive_line(which, bits[i]);
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("queues drained", q_a.size() + q_b.size(), 0);
    endtask

    // Monitor A: picks ready for the coming edge, then scores any word that edge accepts.
    initial begin
        exp_t e;
        bus_a.rx_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                bus_a.rx_ready = hold_a ? 1'b0 : ($urandom_range(0, 3) != 0);
                if (bus_a.overrun) ovr_a++;
                if (bus_a.rx_valid && bus_a.rx_ready) begin
                    if (q_a.size() == 0) begin
                        check("A unexpected word", {23'd0, bus_a.rx_data}, 32'hFFFF_FFFF);
                    end else begin
                        e = q_a.pop_front();
                        $display("A word data=0x%02h perr=%0b ferr=%0b (exp 0x%02h %0b %0b)",
                                 bus_a.rx_data, bus_a.parity_err, bus_a.frame_err,
                                 e.data[7:0], e.perr, e.ferr);
                        check("A data", {24'd0, bus_a.rx_data}, {24'd0, e.data[7:0]});
                        check("A parity_err", {31'd0, bus_a.parity_err}, {31'd0, e.perr});
                        check("A frame_err", {31'd0, bus_a.frame_err}, {31'd0, e.ferr});
                    end
                end
            end
        end
    end

    initial begin
        exp_t e;
        bus_b.rx_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                bus_b.rx_ready = hold_b ? 1'b0 : ($urandom_range(0, 3) != 0);
                if (bus_b.overrun) ovr_b++;
                if (bus_b.rx_valid && bus_b.rx_ready) begin
                    if (q_b.size() == 0) begin
                        check("B unexpected word", {25'd0, bus_b.rx_data}, 32'hFFFF_FFFF);
                    end else begin
                        e = q_b.pop_front();
                        $display("B word data=0x%02h perr=%0b ferr=%0b (exp 0x%02h %0b %0b)",
                                 bus_b.rx_data, bus_b.parity_err, bus_b.frame_err,
                                 e.data[6:0], e.perr, e.ferr);
                        check("B data", {25'd0, bus_b.rx_data}, {25'd0, e.data[6:0]});
                        check("B parity_err", {31'd0, bus_b.parity_err}, 32'd0);
                        check("B frame_err", {31'd0, bus_b.frame_err}, {31'd0, e.ferr});
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int ovr0;
        bit seen;
        repeat (3) @(negedge clk);
        check("reset A outputs", {bus_a.rx_data, bus_a.rx_valid, bus_a.parity_err,
                                  bus_a.frame_err, bus_a.overrun, bus_a.busy}, 0);
        check("reset B outputs", {bus_b.rx_data, bus_b.rx_valid, bus_b.parity_err,
                                  bus_b.frame_err, bus_b.overrun, bus_b.busy}, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Clean 0x41 with start-edge-to-valid latency measured alongside.
        fork
            begin
                n = 0;
                while (!bus_a.rx_valid && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                checks++;
                if (n < 168 || n > 176) begin
                    errors++;
                    $display("FAIL latency actual=%0d required=168..176", n);
                end
            end
            send(0, 9'h41, 1'b0, 1'b0, 2, 1'b1);
        join
        check("busy low after frame", {31'd0, bus_a.busy}, 0);

        // Short low pulse must be rejected without producing a word.
        @(negedge clk);
        rx_a = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch busy in START", {31'd0, bus_a.busy}, 1);
        rx_a = 1'b1;
        n = 0;
        while (bus_a.busy && n < 12) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n > 10) begin
            errors++;
            $display("FAIL glitch busy_low_cycles actual=%0d required<=10", n);
        end
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus_a.rx_valid) seen = 1'b1;
        end
        check("glitch no valid", {31'd0, seen}, 0);

        send(0, 9'h42, 1'b1, 1'b0, 2, 1'b1);

        // Stop bit low, line held low as a break, then a clean word.
        send(0, 9'h55, 1'b0, 1'b1, 0, 1'b1);
        repeat (3 * CPB) @(negedge clk);
        rx_a = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send(0, 9'h0AA, 1'b0, 1'b0, 2, 1'b1);
        wait_drain();

        // Overrun: consumer stalled, second word must be dropped with a single-cycle pulse.
        hold_a = 1'b1;
        @(negedge clk);
        ovr0 = ovr_a;
        send(0, 9'h11, 1'b0, 1'b0, 2, 1'b1);
        send(0, 9'h22, 1'b0, 1'b0, 2, 1'b0);
        check("overrun pulse cycles", ovr_a - ovr0, 1);
        check("overrun data held", {24'd0, bus_a.rx_data}, 32'h11);
        check("overrun valid held", {31'd0, bus_a.rx_valid}, 1);
        hold_a = 1'b0;
        wait_drain();

        // Reset in the middle of a B data field.
        @(negedge clk);
        rx_b = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        check("B busy mid-frame", {31'd0, bus_b.busy}, 1);
        #2 rst_n = 1'b0;
        #1;
        check("B async reset outputs", {bus_b.rx_data, bus_b.rx_valid, bus_b.parity_err,
                                        bus_b.frame_err, bus_b.overrun, bus_b.busy}, 0);
        rx_b = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send(1, 9'h07E, 1'b0, 1'b0, 2, 1'b1);
        send(1, 9'h035, 1'b0, 1'b1, 2, 1'b1);
        wait_drain();

        // Randomised traffic on both receivers.
        for (int i = 0; i < 24; i++) begin
            int   w;
            logic [8:0] d;
            w = $urandom_range(0, 1);
            d = 9'($urandom_range(0, 511));
            send(w, d, (w == 0) && ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 5) == 0), 2, 1'b1);
        end
        wait_drain();
        check("A overrun total", ovr_a, 1);
        check("B overrun total", ovr_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
